// File: rtl/viewport_map_pkg.sv
// Shared constants, state encoding and helpers for the viewport mapping stage.
package viewport_map_pkg;

    localparam int DEF_SCREEN_W = 800;
    localparam int DEF_SCREEN_H = 600;
    localparam int DEF_FRAC     = 16;

    // Command words recognised on the instruction stream
    localparam logic [31:0] GL_TRIANGLES = 32'h0000_0004;
    localparam logic [31:0] GL_COLOR     = 32'h0000_1800;

    // Operand counts following each command
    localparam logic [3:0] TRI_WORDS   = 4'd12;
    localparam logic [3:0] COLOR_WORDS = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_TRI,
        ST_MAP,
        ST_CULL,
        ST_EMIT,
        ST_PASS
    } vp_state_t;

    // Clamp a signed screen coordinate to [0, hi]
    function automatic logic [15:0] clamp_axis(input logic signed [47:0] v,
                                               input logic signed [47:0] hi);
        if (v < 48'sd0)
            return 16'd0;
        else if (v > hi)
            return hi[15:0];
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/viewport_map_vertex.sv
// Combinational NDC-to-screen mapping of one vertex with clamp and
// out-of-range flags taken from the raw NDC coordinates.
module vp_vertex_map
    import viewport_map_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int FRAC     = DEF_FRAC
) (
    input  logic [31:0] i_x,
    input  logic [31:0] i_y,
    output logic [15:0] o_sx,
    output logic [15:0] o_sy,
    output logic        o_x_lo,
    output logic        o_x_hi,
    output logic        o_y_lo,
    output logic        o_y_hi
);

    localparam logic signed [47:0] HALF_W = 48'(SCREEN_W / 2);
    localparam logic signed [47:0] HALF_H = 48'(SCREEN_H / 2);
    localparam logic signed [47:0] MAX_X  = 48'(SCREEN_W - 1);
    localparam logic signed [47:0] MAX_Y  = 48'(SCREEN_H - 1);
    localparam logic signed [47:0] ONE    = 48'sd1 <<< FRAC;

    logic signed [47:0] w_xe, w_ye;
    logic signed [47:0] w_xprod, w_yprod;
    logic signed [47:0] w_sx_raw, w_sy_raw;

    assign w_xe = {{16{i_x[31]}}, i_x};
    assign w_ye = {{16{i_y[31]}}, i_y};

    // Y flips so that NDC +1 lands on the top row
    assign w_xprod  = (w_xe + ONE) * HALF_W;
    assign w_yprod  = (ONE - w_ye) * HALF_H;
    assign w_sx_raw = w_xprod >>> FRAC;
    assign w_sy_raw = w_yprod >>> FRAC;

    assign o_sx = clamp_axis(w_sx_raw, MAX_X);
    assign o_sy = clamp_axis(w_sy_raw, MAX_Y);

    assign o_x_lo = (w_xe < -ONE);
    assign o_x_hi = (w_xe > ONE);
    assign o_y_lo = (w_ye < -ONE);
    assign o_y_hi = (w_ye > ONE);

endmodule

// File: rtl/viewport_map.sv
// Viewport stage ahead of the rasterizer: maps triangle vertices to screen
// pixels, rejects off-screen/degenerate triangles, forwards colour packets.
module viewport_map
    import viewport_map_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int FRAC     = DEF_FRAC
) (
    input  logic        pll_clock,
    input  logic        sys_reset_n,
    input  logic        in_fifo_valid,
    input  logic [31:0] in_fifo_data,
    output logic        in_fifo_ready,
    output logic        raster_fifo_valid,
    output logic [31:0] raster_fifo_data,
    input  logic        raster_fifo_ready,
    output logic [15:0] tri_culled_count
);

    vp_state_t   r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_vbuf [0:11];
    logic [15:0] r_sx   [0:2];
    logic [15:0] r_sy   [0:2];
    logic [2:0]  r_xlo, r_xhi, r_ylo, r_yhi;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic [15:0] r_cull_cnt;

    logic [3:0]  w_vidx;
    logic [15:0] w_sx, w_sy;
    logic        w_x_lo, w_x_hi, w_y_lo, w_y_hi;
    logic        w_fire_in, w_out_free, w_reject;
    logic signed [31:0] w_sx0, w_sx1, w_sx2, w_sy0, w_sy1, w_sy2, w_area;
    logic [3:0]  w_k;
    logic [31:0] w_emit_word;

    // r_cnt selects the vertex being mapped during MAP
    assign w_vidx = {r_cnt[1:0], 2'b00};

    vp_vertex_map #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .FRAC     (FRAC)
    ) u_vertex_map (
        .i_x    (r_vbuf[w_vidx]),
        .i_y    (r_vbuf[w_vidx + 4'd1]),
        .o_sx   (w_sx),
        .o_sy   (w_sy),
        .o_x_lo (w_x_lo),
        .o_x_hi (w_x_hi),
        .o_y_lo (w_y_lo),
        .o_y_hi (w_y_hi)
    );

    assign w_out_free = !r_out_valid || raster_fifo_ready;
    assign w_fire_in  = in_fifo_valid && in_fifo_ready;

    assign w_sx0 = {16'd0, r_sx[0]};
    assign w_sx1 = {16'd0, r_sx[1]};
    assign w_sx2 = {16'd0, r_sx[2]};
    assign w_sy0 = {16'd0, r_sy[0]};
    assign w_sy1 = {16'd0, r_sy[1]};
    assign w_sy2 = {16'd0, r_sy[2]};
    assign w_area = (w_sx1 - w_sx0) * (w_sy2 - w_sy0) - (w_sx2 - w_sx0) * (w_sy1 - w_sy0);
    assign w_reject = (&r_xlo) | (&r_xhi) | (&r_ylo) | (&r_yhi);

    // Input acceptance: always open in IDLE/LOAD, follows output space in PASS
    always_comb begin
        in_fifo_ready = 1'b0;
        case (r_state)
            ST_IDLE, ST_LOAD_TRI: in_fifo_ready = 1'b1;
            ST_PASS:              in_fifo_ready = (r_cnt != COLOR_WORDS) && w_out_free;
            default:              in_fifo_ready = 1'b0;
        endcase
    end

    // Output word selection for EMIT: index 0 is the command, then x,y,z,w per vertex
    always_comb begin
        w_k         = r_cnt - 4'd1;
        w_emit_word = GL_TRIANGLES;
        if (r_cnt != 4'd0) begin
            case (w_k[1:0])
                2'd0:    w_emit_word = {16'd0, r_sx[w_k[3:2]]};
                2'd1:    w_emit_word = {16'd0, r_sy[w_k[3:2]]};
                2'd2:    w_emit_word = r_vbuf[{w_k[3:2], 2'b10}];
                default: w_emit_word = r_vbuf[{w_k[3:2], 2'b11}];
            endcase
        end
    end

    // Main FSM with vertex buffer, mapped coordinates, output register and cull counter
    always_ff @(posedge pll_clock or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            for (int i = 0; i < 12; i++) r_vbuf[i] <= '0;
            for (int i = 0; i < 3; i++) begin
                r_sx[i] <= '0;
                r_sy[i] <= '0;
            end
            r_xlo       <= '0;
            r_xhi       <= '0;
            r_ylo       <= '0;
            r_yhi       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_cull_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (in_fifo_valid) begin
                        if (in_fifo_data == GL_TRIANGLES) begin
                            r_state <= ST_LOAD_TRI;
                        end else if (in_fifo_data == GL_COLOR) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= in_fifo_data;
                            r_state     <= ST_PASS;
                        end
                    end
                end
                ST_LOAD_TRI: begin
                    if (in_fifo_valid) begin
                        r_vbuf[r_cnt] <= in_fifo_data;
                        if (r_cnt == TRI_WORDS - 4'd1) begin
                            r_cnt   <= '0;
                            r_state <= ST_MAP;
                        end else begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                ST_MAP: begin
                    r_sx[r_cnt[1:0]]  <= w_sx;
                    r_sy[r_cnt[1:0]]  <= w_sy;
                    r_xlo[r_cnt[1:0]] <= w_x_lo;
                    r_xhi[r_cnt[1:0]] <= w_x_hi;
                    r_ylo[r_cnt[1:0]] <= w_y_lo;
                    r_yhi[r_cnt[1:0]] <= w_y_hi;
                    if (r_cnt == 4'd2) begin
                        r_cnt   <= '0;
                        r_state <= ST_CULL;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_CULL: begin
                    r_cnt <= '0;
                    if (w_reject || (w_area == 32'sd0)) begin
                        r_cull_cnt <= r_cull_cnt + 16'd1;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_out_free) begin
                        if (r_cnt <= TRI_WORDS) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_emit_word;
                            r_cnt       <= r_cnt + 4'd1;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_IDLE;
                        end
                    end
                end
                ST_PASS: begin
                    if (w_fire_in) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= in_fifo_data;
                        r_cnt       <= r_cnt + 4'd1;
                    end else if (w_out_free) begin
                        r_out_valid <= 1'b0;
                        if (r_cnt == COLOR_WORDS)
                            r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign raster_fifo_valid = r_out_valid;
    assign raster_fifo_data  = r_out_data;
    assign tri_culled_count  = r_cull_cnt;

endmodule
